fifo_access_ctrl: RTL and testbench

//  Sequences all access to one single-port-per-cycle FIFO. It arbitrates NUM_WR

---
 rtl/fifo_access_ctrl_if.sv | 36 +++
 rtl/fifo_access_ctrl.sv | 113 +++++++++++
 tb/tb_fifo_access_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_access_ctrl_if.sv
// Bus bundle between the FIFO access controller, its producer/consumer agents
// and the FIFO instance. The controller connects through the slave modport.
interface fifo_access_ctrl_if #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_WR     = 4,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
);
  logic [NUM_WR-1:0]            wr_req;
  logic [NUM_WR*FIFO_WIDTH-1:0] wr_data;
  logic [NUM_WR-1:0]            wr_gnt;
  logic                         rd_req;
  logic                         rd_gnt;
  logic                         rd_valid;
  logic [FIFO_WIDTH-1:0]        rd_data;
  logic                         fifo_wr_en;
  logic [FIFO_WIDTH-1:0]        fifo_data_in;
  logic                         fifo_rd_en;
  logic [FIFO_WIDTH-1:0]        fifo_data_out;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [CW-1:0]                count;
  logic                         sync_err;

  modport slave (
    input  wr_req, wr_data, rd_req, fifo_data_out, fifo_full, fifo_empty,
    output wr_gnt, rd_gnt, rd_valid, rd_data, fifo_wr_en, fifo_data_in,
           fifo_rd_en, count, sync_err
  );

  modport master (
    output wr_req, wr_data, rd_req, fifo_data_out, fifo_full, fifo_empty,
    input  wr_gnt, rd_gnt, rd_valid, rd_data, fifo_wr_en, fifo_data_in,
           fifo_rd_en, count, sync_err
  );
endinterface

// File: rtl/fifo_access_ctrl.sv
// Single-op-per-cycle FIFO access controller: round-robin arbitration of the
// write producers, read/write alternation under contention, a shadow occupancy
// count that gates ops, and a sticky error when the FIFO flags disagree with it.
module fifo_access_ctrl #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_WR     = 4
) (
  input  logic                clk,
  input  logic                rstN,
  fifo_access_ctrl_if.slave   bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  state_t            last;
  state_t            last_next;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     rr_ptr;
  logic              rd_valid_q;
  logic              sync_err_q;
  logic              wr_ok;
  logic              rd_ok;
  logic              do_wr;
  logic              do_rd;
  logic              found;
  int                scan_idx;
  logic [PW-1:0]     sel;
  logic [NUM_WR-1:0] gnt_vec;

  // Pick the first requesting producer starting from the round-robin pointer
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_WR; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_WR;
      if (!found && bus.wr_req[PW'(scan_idx)]) begin
        sel   = PW'(scan_idx);
        found = 1'b1;
      end
    end
  end

  // Decide this cycle's single op and the next value of the last-op FSM
  always_comb begin
    wr_ok = (|bus.wr_req) && (count_q < CW'(FIFO_DEPTH)) && !bus.fifo_full;
    rd_ok = bus.rd_req && (count_q != '0) && !bus.fifo_empty;
    do_wr = 1'b0;
    do_rd = 1'b0;
    if (wr_ok && rd_ok) begin
      if (last == S_WR) do_rd = 1'b1;
      else              do_wr = 1'b1;
    end else if (wr_ok) begin
      do_wr = 1'b1;
    end else if (rd_ok) begin
      do_rd = 1'b1;
    end
    if (!rstN) begin
      do_wr = 1'b0;
      do_rd = 1'b0;
    end
    last_next = last;
    if (do_wr)      last_next = S_WR;
    else if (do_rd) last_next = S_RD;
  end

  // Expand the selected producer into a one-hot grant
  always_comb begin
    gnt_vec = '0;
    if (do_wr) gnt_vec[sel] = 1'b1;
  end

  assign bus.wr_gnt       = gnt_vec;
  assign bus.rd_gnt       = do_rd;
  assign bus.fifo_wr_en   = do_wr;
  assign bus.fifo_rd_en   = do_rd;
  assign bus.fifo_data_in = do_wr ? bus.wr_data[int'(sel)*FIFO_WIDTH +: FIFO_WIDTH]
                                  : '0;
  assign bus.rd_data      = bus.fifo_data_out;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.sync_err     = sync_err_q;

  // Last-op state register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) last <= S_IDLE;
    else       last <= last_next;
  end

  // Occupancy, round-robin pointer, read-valid pipeline and sticky flag check
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count_q    <= '0;
      rr_ptr     <= '0;
      rd_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      if (do_wr) begin
        count_q <= count_q + CW'(1);
        rr_ptr  <= PW'((int'(sel) + 1) % NUM_WR);
      end else if (do_rd) begin
        count_q <= count_q - CW'(1);
      end
      rd_valid_q <= do_rd;
      if (((count_q == '0) != bus.fifo_empty) ||
          ((count_q == CW'(FIFO_DEPTH)) != bus.fifo_full))
        sync_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed table-driven bench for fifo_access_ctrl with a behavioural FIFO
// attached to its FIFO-side ports.
module tb_fifo_access_ctrl;
  localparam int W = 32;
  localparam int D = 16;
  localparam int N = 4;

  typedef struct {
    bit         rst_before;
    logic [3:0] wr_req;
    logic       rd_req;
    logic [3:0] exp_wr_gnt;
    logic       exp_rd_gnt;
    logic       exp_rd_valid;
    logic [4:0] exp_count;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  logic force_not_empty = 1'b0;
  int   tests = 0;
  int   failed = 0;
  vec_t vecs[$];
  logic [W-1:0] exp_q[$];

  logic [W-1:0] mem [D];
  logic [4:0]   f_cnt;
  logic [3:0]   f_wp;
  logic [3:0]   f_rp;

  fifo_access_ctrl_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .NUM_WR(N)) bus ();

  fifo_access_ctrl #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .NUM_WR(N)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO with registered read data, reset alongside the controller
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      f_cnt <= '0;
      f_wp <= '0;
      f_rp <= '0;
      bus.fifo_data_out <= '0;
    end else begin
      if (bus.fifo_wr_en) begin
        mem[f_wp] <= bus.fifo_data_in;
        f_wp <= f_wp + 4'd1;
      end
      if (bus.fifo_rd_en) begin
        bus.fifo_data_out <= mem[f_rp];
        f_rp <= f_rp + 4'd1;
      end
      f_cnt <= f_cnt + {4'd0, bus.fifo_wr_en} - {4'd0, bus.fifo_rd_en};
    end
  end

  assign bus.fifo_full  = (f_cnt == 5'd16);
  assign bus.fifo_empty = (f_cnt == 5'd0) && !force_not_empty;

  function automatic logic [W-1:0] pdata(int i, int n);
    return {8'hA0 + 8'(i), 8'(n), 16'h5A5A};
  endfunction

  function automatic int onehot_idx(logic [3:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic void add(bit rb, logic [3:0] wr, logic rd, logic [3:0] eg,
                              logic erg, logic erv, int ec);
    vec_t v;
    v.rst_before   = rb;
    v.wr_req       = wr;
    v.rd_req       = rd;
    v.exp_wr_gnt   = eg;
    v.exp_rd_gnt   = erg;
    v.exp_rd_valid = erv;
    v.exp_count    = 5'(ec);
    vecs.push_back(v);
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstN = 1'b0;
    bus.wr_req = '0;
    bus.rd_req = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(vec_t v, int n);
    bus.wr_req = v.wr_req;
    bus.rd_req = v.rd_req;
    for (int i = 0; i < N; i++) bus.wr_data[i*W +: W] = pdata(i, n);
  endtask

  task automatic run_vector(vec_t v, int n);
    logic [W-1:0] e;
    if (v.rst_before) pulse_reset();
    apply_stimulus(v, n);
    @(negedge clk);
    check_output($sformatf("v%0d wr_gnt", n), bus.wr_gnt, v.exp_wr_gnt);
    check_output($sformatf("v%0d rd_gnt", n), bus.rd_gnt, v.exp_rd_gnt);
    check_output($sformatf("v%0d fifo_wr_en", n), bus.fifo_wr_en, |v.exp_wr_gnt);
    check_output($sformatf("v%0d fifo_rd_en", n), bus.fifo_rd_en, v.exp_rd_gnt);
    check_output($sformatf("v%0d one_op", n), bus.fifo_wr_en & bus.fifo_rd_en, 0);
    check_output($sformatf("v%0d rd_valid", n), bus.rd_valid, v.exp_rd_valid);
    check_output($sformatf("v%0d sync_err", n), bus.sync_err, 0);
    e = (v.exp_wr_gnt != 0) ? pdata(onehot_idx(v.exp_wr_gnt), n) : '0;
    check_output($sformatf("v%0d fifo_data_in", n), bus.fifo_data_in, e);
    if (v.exp_rd_valid) begin
      if (exp_q.size() == 0) check_output($sformatf("v%0d rd_data_queue", n), 1, 0);
      else check_output($sformatf("v%0d rd_data", n), bus.rd_data, exp_q.pop_front());
    end
    if (v.exp_wr_gnt != 0) exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_output($sformatf("v%0d count", n), bus.count, v.exp_count);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Main sequence
  initial begin
    // Round robin over all four producers, then drain two
    add(1, 4'hF, 0, 4'h1, 0, 0, 1);
    add(0, 4'hF, 0, 4'h2, 0, 0, 2);
    add(0, 4'hF, 0, 4'h4, 0, 0, 3);
    add(0, 4'hF, 0, 4'h8, 0, 0, 4);
    add(0, 4'hF, 0, 4'h1, 0, 0, 5);
    add(0, 4'hF, 0, 4'h2, 0, 0, 6);
    add(0, 4'hF, 0, 4'h4, 0, 0, 7);
    add(0, 4'hF, 0, 4'h8, 0, 0, 8);
    add(0, 4'h0, 1, 4'h0, 1, 0, 7);
    add(0, 4'h0, 1, 4'h0, 1, 1, 6);
    add(0, 4'h0, 0, 4'h0, 0, 1, 6);
    // Fill to full with a single producer; extra requests are refused
    for (int i = 0; i < 20; i++)
      add(i == 0, 4'h1, 0, (i < 16) ? 4'h1 : 4'h0, 0, 0, (i < 16) ? i + 1 : 16);
    // Five writes, then contended read/write alternation starting with a read
    for (int i = 0; i < 5; i++) add(i == 0, 4'h2, 0, 4'h2, 0, 0, i + 1);
    for (int i = 0; i < 8; i++)
      add(0, 4'h2, 1, (i % 2 == 1) ? 4'h2 : 4'h0, (i % 2 == 0),
          (i % 2 == 1), (i % 2 == 0) ? 4 : 5);
    // Read refused while empty, then write, read, and delayed read data
    add(1, 4'h0, 1, 4'h0, 0, 0, 0);
    add(0, 4'h1, 1, 4'h1, 0, 0, 1);
    add(0, 4'h0, 1, 4'h0, 1, 0, 0);
    add(0, 4'h0, 1, 4'h0, 0, 1, 0);
    // Pointer skips idle producers
    add(1, 4'h5, 0, 4'h1, 0, 0, 1);
    add(0, 4'h5, 0, 4'h4, 0, 0, 2);
    add(0, 4'h5, 0, 4'h1, 0, 0, 3);
    add(0, 4'hA, 0, 4'h2, 0, 0, 4);
    add(0, 4'hA, 0, 4'h8, 0, 0, 5);
    add(0, 4'hA, 0, 4'h2, 0, 0, 6);
    add(0, 4'h0, 1, 4'h0, 1, 0, 5);
    add(0, 4'h0, 1, 4'h0, 1, 1, 4);
    add(0, 4'h0, 0, 4'h0, 0, 1, 4);

    // Reset asserted with all producers requesting
    rstN = 1'b0;
    bus.wr_req = 4'hF;
    bus.rd_req = 1'b0;
    bus.wr_data = '0;
    #3;
    check_output("reset wr_gnt", bus.wr_gnt, 0);
    check_output("reset fifo_wr_en", bus.fifo_wr_en, 0);
    check_output("reset count", bus.count, 0);
    check_output("reset rd_valid", bus.rd_valid, 0);
    check_output("reset sync_err", bus.sync_err, 0);
    bus.wr_req = '0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < vecs.size(); n++) run_vector(vecs[n], n);

    // Flag mismatch makes sync_err sticky
    pulse_reset();
    force_not_empty = 1'b1;
    @(posedge clk);
    #1;
    check_output("err set", bus.sync_err, 1);
    force_not_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("err sticky", bus.sync_err, 1);

    // Reset in the middle of a write burst drops grants immediately
    bus.wr_req = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check_output("burst gnt active", |bus.wr_gnt, 1);
    #2;
    rstN = 1'b0;
    #1;
    check_output("midreset wr_gnt", bus.wr_gnt, 0);
    check_output("midreset fifo_wr_en", bus.fifo_wr_en, 0);
    check_output("midreset fifo_rd_en", bus.fifo_rd_en, 0);
    check_output("midreset sync_err", bus.sync_err, 0);
    check_output("midreset count", bus.count, 0);
    bus.wr_req = '0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    check_output("post reset count", bus.count, 0);
    check_output("post reset sync_err", bus.sync_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
